// File: rtl/fsm.sv
// Keypad combination lock for code A-B-C-B-A; progress exposes the state code (IDLE=0 .. OPEN=5).
// Build option FSM_AUTO_RELOCK_EN adds a timer that returns OPEN to IDLE after RELOCK_CYCLES cycles.
module fsm #(
    parameter int unsigned RELOCK_CYCLES = 16
) (
    input  logic       x1,
    input  logic       x0,
    input  logic       clk,
    input  logic       reset,
    output logic       unlock,
    output logic       fail,
    output logic [2:0] progress
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_A    = 3'd1,
        S_AB   = 3'd2,
        S_ABC  = 3'd3,
        S_ABCB = 3'd4,
        OPEN   = 3'd5
    } state_t;

    localparam logic [1:0] KEY_NONE = 2'd0;
    localparam logic [1:0] KEY_A    = 2'd1;
    localparam logic [1:0] KEY_B    = 2'd2;
    localparam logic [1:0] KEY_C    = 2'd3;

    if (RELOCK_CYCLES < 1 || RELOCK_CYCLES > 65535) begin : g_bad_relock
        $error("RELOCK_CYCLES out of range 1..65535");
    end

    state_t     state;
    state_t     state_nxt;
    logic       fail_nxt;
    logic       relock_due;
    logic [1:0] key;
    logic [1:0] want;

    assign key = {x1, x0};

`ifdef FSM_AUTO_RELOCK_EN
    localparam logic [15:0] RELOCK_LAST = 16'(RELOCK_CYCLES - 1);

    logic [15:0] open_cnt;

    // Held at zero outside OPEN, so the count starts fresh on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            open_cnt <= '0;
        end else if (state != OPEN) begin
            open_cnt <= '0;
        end else begin
            open_cnt <= open_cnt + 16'd1;
        end
    end

    assign relock_due = (open_cnt == RELOCK_LAST);
`else
    assign relock_due = 1'b0;
`endif

    always_comb begin
        want = KEY_NONE;
        case (state)
            IDLE:    want = KEY_A;
            S_A:     want = KEY_B;
            S_AB:    want = KEY_C;
            S_ABC:   want = KEY_B;
            S_ABCB:  want = KEY_A;
            default: want = KEY_NONE;
        endcase
    end

    always_comb begin
        state_nxt = state;
        fail_nxt  = 1'b0;
        case (state)
            IDLE, S_A, S_AB, S_ABC, S_ABCB: begin
                if (key != KEY_NONE) begin
                    if (key == want) begin
                        state_nxt = state_t'(state + 3'd1);
                    end else begin
                        // A wrong A still counts as a fresh first symbol.
                        state_nxt = (key == KEY_A) ? S_A : IDLE;
                        fail_nxt  = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (relock_due) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            unlock <= 1'b0;
            fail   <= 1'b0;
        end else begin
            state  <= state_nxt;
            unlock <= (state_nxt == OPEN);
            fail   <= fail_nxt;
        end
    end

    assign progress = state;

endmodule

// File: tb/tb_fsm.sv
// Scoreboard bench for the combination lock: directed sequences plus random keys checked
// against a code-index model; expectations are queued by the driver and popped by a monitor.
module tb_fsm;
`ifdef FSM_AUTO_RELOCK_EN
    localparam int RELOCK = 4;
`else
    localparam int RELOCK = 16;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       x1;
    logic       x0;
    logic       unlock;
    logic       fail;
    logic [2:0] progress;

    fsm #(.RELOCK_CYCLES(RELOCK)) dut (
        .x1(x1), .x0(x0), .clk(clk), .reset(reset),
        .unlock(unlock), .fail(fail), .progress(progress)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] prog;
        logic       unl;
        logic       fl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Model: number of code symbols matched so far (5 = open).
    int   m_idx = 0;
    int   code[5] = '{1, 2, 3, 2, 1};
`ifdef FSM_AUTO_RELOCK_EN
    int   m_open_left = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit rst, input logic [1:0] k);
        exp_t e;
        bit   f;
        f = 1'b0;
        @(negedge clk);
        reset = rst;
        {x1, x0} = k;
        if (rst) begin
            m_idx = 0;
        end else if (m_idx == 5) begin
`ifdef FSM_AUTO_RELOCK_EN
            m_open_left--;
            if (m_open_left == 0) m_idx = 0;
`endif
        end else if (k != 2'd0) begin
            if (int'(k) == code[m_idx]) begin
                m_idx++;
`ifdef FSM_AUTO_RELOCK_EN
                if (m_idx == 5) m_open_left = RELOCK;
`endif
            end else begin
                m_idx = (k == 2'd1) ? 1 : 0;
                f = 1'b1;
            end
        end
        e.prog = 3'(m_idx);
        e.unl  = (m_idx == 5);
        e.fl   = f;
        exp_q.push_back(e);
    endtask

    // Letters A/B/C are keys, '-' is no entry, 'R' is a reset cycle.
    task automatic run_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "A":     step(1'b0, 2'd1);
                "B":     step(1'b0, 2'd2);
                "C":     step(1'b0, 2'd3);
                "R":     step(1'b1, 2'd0);
                default: step(1'b0, 2'd0);
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("progress", int'(progress), int'(e.prog));
                chk("unlock", int'(unlock), int'(e.unl));
                chk("fail", int'(fail), int'(e.fl));
            end
        end
    end

    initial begin
        logic [1:0] k;
        reset = 1'b1;
        x1 = 1'b0;
        x0 = 1'b0;
        step(1'b1, 2'd0);
        step(1'b1, 2'd3);
        run_str("BABCBAAAAAAA");
        run_str("RABA--C-BA");
        run_str("RABCCABCBBABCBA");
        run_str("RAABCBBAABCBACCC");
        step(1'b1, 2'd3);
        run_str("ABCBA--");
        run_str("RCA");
        run_str("RBCAABACABCAB");
        run_str("RABCBACBA----ABCBA");
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 1 && m_idx < 5) k = 2'(code[m_idx]);
            else k = 2'($urandom_range(0, 3));
            step($urandom_range(0, 59) == 0, k);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
